// File: rtl/cd_local_dxbar_2x4.sv
`default_nettype none
// ============================================================================
//  Module      : cd_local_dxbar_2x4
//  Description : Local diverge crossbar on the reply path. Two converged reply
//                inputs are steered to four router outputs by the 2-bit
//                destination field carried in each flit. Each output owns a
//                registered one-entry slot and a two-way round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module cd_local_dxbar_2x4 #(
    parameter int DATA_W  = 64,
    parameter int DST_LSB = 0
) (
    input  logic                clk,
    input  logic                reset,      // asynchronous, active-low
    input  logic [1:0]          cv_si_r,
    output logic [1:0]          cv_ri_r,
    input  logic [2*DATA_W-1:0] cv_di_r,
    output logic [3:0]          out_so,
    input  logic [3:0]          out_ro,
    output logic [4*DATA_W-1:0] out_do
);

    localparam int c_NUM_IN  = 2;
    localparam int c_NUM_OUT = 4;

    // Per-input flit and its destination field
    logic [DATA_W-1:0]   w_flit [c_NUM_IN];
    logic [1:0]          w_dst  [c_NUM_IN];

    // Per-output request vector, arbitration result and slot control
    logic [c_NUM_IN-1:0] w_req  [c_NUM_OUT];
    logic [c_NUM_IN-1:0] w_gnt  [c_NUM_OUT];
    logic [c_NUM_OUT-1:0] w_can_acc;
    logic [c_NUM_OUT-1:0] w_acc;
    logic [c_NUM_OUT-1:0] w_drain;
    logic [c_NUM_OUT-1:0] w_sel;           // index of the winning input
    logic [c_NUM_IN-1:0]  w_rdy;

    // Output slots and round-robin pointers
    logic [c_NUM_OUT-1:0] r_full;
    logic [c_NUM_OUT-1:0] r_ptr;
    logic [DATA_W-1:0]    r_data [c_NUM_OUT];

    generate
        for (genvar gi = 0; gi < c_NUM_IN; gi++) begin : g_in
            assign w_flit[gi] = cv_di_r[DATA_W*gi +: DATA_W];
            assign w_dst[gi]  = w_flit[gi][DST_LSB +: 2];
        end

        for (genvar go = 0; go < c_NUM_OUT; go++) begin : g_out
            assign out_so[go]                    = r_full[go];
            assign out_do[DATA_W*go +: DATA_W]   = r_data[go];
        end
    endgenerate

    // Request decode and per-output round-robin arbitration
    always_comb begin
        for (int o = 0; o < c_NUM_OUT; o++) begin
            for (int i = 0; i < c_NUM_IN; i++) begin
                w_req[o][i] = cv_si_r[i] & (w_dst[i] == 2'(o));
            end
            // A full slot that drains this cycle can take a new flit at once
            w_can_acc[o] = ~r_full[o] | out_ro[o];
            // Two requesters: pointer decides; one requester: it wins
            w_sel[o]     = (&w_req[o]) ? r_ptr[o] : w_req[o][1];
            w_acc[o]     = (|w_req[o]) & w_can_acc[o];
            w_gnt[o]     = w_acc[o] ? (w_sel[o] ? 2'b10 : 2'b01) : 2'b00;
            w_drain[o]   = r_full[o] & out_ro[o];
        end
    end

    // Input ready: an input targets one output only, so OR of grants is safe
    always_comb begin
        w_rdy = '0;
        for (int o = 0; o < c_NUM_OUT; o++) begin
            w_rdy = w_rdy | w_gnt[o];
        end
        // No handshakes can complete while reset is held
        cv_ri_r = reset ? w_rdy : 2'b00;
    end

    // Output slot, data register and round-robin pointer update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= '0;
            r_ptr  <= '0;
            for (int o = 0; o < c_NUM_OUT; o++) begin
                r_data[o] <= '0;
            end
        end else begin
            for (int o = 0; o < c_NUM_OUT; o++) begin
                if (w_acc[o]) begin
                    r_full[o] <= 1'b1;
                    r_data[o] <= w_flit[w_sel[o]];
                    // Hand priority to the other input
                    r_ptr[o]  <= ~w_sel[o];
                end else if (w_drain[o]) begin
                    r_full[o] <= 1'b0;
                    r_data[o] <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cd_local_dxbar_2x4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cd_local_dxbar_2x4
//  Description : Self-checking bench for cd_local_dxbar_2x4. Directed
//                scenarios followed by randomized traffic, all compared
//                against a slot/pointer reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cd_local_dxbar_2x4;

    localparam int DW = 64;

    logic            clk;
    logic            reset;
    logic [1:0]      cv_si_r;
    logic [1:0]      cv_ri_r;
    logic [2*DW-1:0] cv_di_r;
    logic [3:0]      out_so;
    logic [3:0]      out_ro;
    logic [4*DW-1:0] out_do;

    cd_local_dxbar_2x4 #(.DATA_W(DW), .DST_LSB(0)) u_dut (
        .clk     (clk),
        .reset   (reset),
        .cv_si_r (cv_si_r),
        .cv_ri_r (cv_ri_r),
        .cv_di_r (cv_di_r),
        .out_so  (out_so),
        .out_ro  (out_ro),
        .out_do  (out_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what each router port currently holds
    bit          m_full [4];
    logic [63:0] m_data [4];
    bit          m_ptr  [4];   // input that wins the next tie on this port

    logic [1:0]  last_rdy;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < 4; o++) begin
            m_full[o] = 1'b0;
            m_data[o] = '0;
            m_ptr[o]  = 1'b0;
        end
    endtask

    function automatic logic [63:0] mk_flit(input logic [61:0] payload, input int dst);
        return {payload, 2'(dst)};
    endfunction

    // One clock cycle: drive inputs, check ready against the model, advance
    // the model across the edge, then check the registered outputs.
    task automatic cycle(input logic [1:0] vin, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [3:0] ro, output logic [1:0] acc);
        int          win [4];
        logic [1:0]  exp_rdy;
        logic [3:0]  exp_so;
        logic [255:0] exp_do;
        logic [63:0] flit [2];
        flit[0] = d0;
        flit[1] = d1;
        cv_si_r = vin;
        cv_di_r = {d1, d0};
        out_ro  = ro;
        #1;
        exp_rdy = 2'b00;
        for (int o = 0; o < 4; o++) begin
            int cands[$];
            for (int i = 0; i < 2; i++)
                if (vin[i] && int'(flit[i][1:0]) == o) cands.push_back(i);
            win[o] = -1;
            if (cands.size() > 0 && (!m_full[o] || ro[o]))
                win[o] = (cands.size() == 2) ? int'(m_ptr[o]) : cands[0];
            if (win[o] >= 0) exp_rdy[win[o]] = 1'b1;
        end
        check("ready", cv_ri_r, exp_rdy);
        last_rdy = cv_ri_r;
        @(posedge clk);
        for (int o = 0; o < 4; o++) begin
            if (win[o] >= 0) begin
                m_full[o] = 1'b1;
                m_data[o] = flit[win[o]];
                m_ptr[o]  = (win[o] == 0);
            end else if (m_full[o] && ro[o]) begin
                m_full[o] = 1'b0;
                m_data[o] = '0;
            end
        end
        #1;
        for (int o = 0; o < 4; o++) begin
            exp_so[o]          = m_full[o];
            exp_do[64*o +: 64] = m_data[o];
        end
        check("out_so", out_so, exp_so);
        check("out_do", out_do, exp_do);
        acc = exp_rdy;
    endtask

    logic [1:0]  acc;
    logic [63:0] a, b;
    logic [1:0]  rr_exp [4];
    bit          pend_v [2];
    logic [63:0] pend_d [2];

    initial begin
        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        model_reset();

        // Reset with both inputs asserting valid
        reset   = 1'b0;
        cv_si_r = 2'b11;
        cv_di_r = {mk_flit(62'h1, 0), mk_flit(62'h2, 1)};
        out_ro  = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", cv_ri_r, 2'b00);
        check("rst_so", out_so, 4'h0);
        check("rst_do", out_do, '0);
        reset = 1'b1;

        // Single route to port 2
        a = mk_flit(62'hA5, 2);
        cycle(2'b01, a, '0, 4'hF, acc);
        check("single_rdy", last_rdy, 2'b01);
        check("single_so", out_so, 4'b0100);
        check("single_do2", out_do[128 +: 64], a);

        // Parallel routes: in0 -> 1, in1 -> 3
        a = mk_flit(62'h1111, 1);
        b = mk_flit(62'h3333, 3);
        cycle(2'b11, a, b, 4'hF, acc);
        check("par_rdy", last_rdy, 2'b11);
        check("par_so", out_so, 4'b1010);
        check("par_do1", out_do[64 +: 64], a);
        check("par_do3", out_do[192 +: 64], b);

        // Contention on port 0: grants must alternate starting with in0
        a = mk_flit(62'h100, 0);
        b = mk_flit(62'h200, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(2'b11, a, b, 4'hF, acc);
            check("rr_gnt", last_rdy, rr_exp[k]);
            check("rr_do0", out_do[63:0], acc[0] ? a : b);
            if (acc[0]) a = mk_flit(62'h101 + 62'(k), 0);
            if (acc[1]) b = mk_flit(62'h201 + 62'(k), 0);
        end

        // Backpressure on port 1
        a = mk_flit(62'hB0, 1);
        cycle(2'b01, a, '0, 4'hD, acc);
        b = mk_flit(62'hB1, 1);
        cycle(2'b01, b, '0, 4'hD, acc);
        check("bp_rdy_blocked", last_rdy, 2'b00);
        check("bp_do1_held", out_do[64 +: 64], a);
        cycle(2'b01, b, '0, 4'hF, acc);
        check("bp_rdy_release", last_rdy, 2'b01);
        check("bp_so1", out_so[1], 1'b1);
        check("bp_do1_new", out_do[64 +: 64], b);

        // Asynchronous reset mid-stream with slot 0 full
        a = mk_flit(62'hC0, 0);
        cycle(2'b01, a, '0, 4'hE, acc);   // in0 wins port 0, pointer moves to in1
        check("ar_so0_pre", out_so[0], 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_so_now", out_so, 4'h0);
        check("ar_rdy_now", cv_ri_r, 2'b00);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        a = mk_flit(62'hD0, 0);
        b = mk_flit(62'hD1, 0);
        cycle(2'b11, a, b, 4'hF, acc);
        check("ar_ptr0", last_rdy, 2'b01);

        // Randomized traffic; unaccepted flits are held stable
        for (int i = 0; i < 2; i++) begin
            pend_v[i] = 1'b0;
            pend_d[i] = '0;
        end
        for (int c = 0; c < 400; c++) begin
            logic [3:0] ro;
            for (int i = 0; i < 2; i++) begin
                if (!pend_v[i]) begin
                    pend_v[i] = ($urandom_range(0, 3) != 0);
                    pend_d[i] = {$urandom, $urandom};
                end
            end
            ro = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            cycle({pend_v[1], pend_v[0]}, pend_d[0], pend_d[1], ro, acc);
            for (int i = 0; i < 2; i++)
                if (acc[i]) pend_v[i] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
